acc_bank: RTL

- Parametrised multi-channel accumulator bank; next generation of the single 16-bit core accumulator.
- One accumulator per core channel, selected by a per-channel encoded opcode, so there is no overlapping-enable priority ambiguity.
- Adds decrement, saturate/wrap mode, zero/carry flags, and a per-channel save/restore stack for subroutine-style accumulator spills.
- Sits between each core's control unit and its ALU; data_out feeds the ALU A-input and the memory write path.

---
 rtl/acc_pkg.sv | 17 +
 rtl/acc_channel.sv | 153 +++++++++++++++
 rtl/acc_bank.sv | 55 +++++
 3 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the accumulator bank.
// Holds the per-channel opcode encoding and its width. acc_channel
// decodes these values and acc_bank uses OP_W to slice its op bus.
package acc_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
    localparam logic [OP_W-1:0] OP_LOAD  = 3'd1;
    localparam logic [OP_W-1:0] OP_INC   = 3'd2;
    localparam logic [OP_W-1:0] OP_DEC   = 3'd3;
    localparam logic [OP_W-1:0] OP_ALU   = 3'd4;
    localparam logic [OP_W-1:0] OP_CLEAR = 3'd5;
    localparam logic [OP_W-1:0] OP_PUSH  = 3'd6;
    localparam logic [OP_W-1:0] OP_POP   = 3'd7;

endpackage

// File: rtl/acc_channel.sv
// acc_channel: one accumulator with carry, zero flag and a LIFO
// save/restore stack with a sticky overflow/underflow error.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   op_i            encoded opcode (see acc_pkg)
//   dataIn_i        value for LOAD
//   aluOut_i        value for ALU
//   errClr_i        clears the sticky stack error
//   dataOut_o       accumulator value
//   zero_o          accumulator is zero
//   carry_o         carry/borrow from the last INC/DEC
//   stkFull_o       stack holds DEPTH entries
//   stkEmpty_o      stack holds no entries
//   stkErr_o        sticky push-when-full / pop-when-empty
module acc_channel
    import acc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int SAT   = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] dataIn_i,
    input  logic [WIDTH-1:0] aluOut_i,
    input  logic             errClr_i,
    output logic [WIDTH-1:0] dataOut_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             stkFull_o,
    output logic             stkEmpty_o,
    output logic             stkErr_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] accQ, accD;
    logic             carryQ, carryD;
    logic             errQ, errD;
    logic [CW-1:0]    cntQ, cntD;
    logic [WIDTH-1:0] stackQ [DEPTH];

    logic             full;
    logic             empty;
    logic             pushEn;
    logic             errSet;
    logic [AW-1:0]    pushIdx;
    logic [AW-1:0]    popIdx;

    // Stack occupancy flags come straight from the registered count so
    // they line up with dataOut_o in the same cycle.
    assign full    = (cntQ == CW'(DEPTH));
    assign empty   = (cntQ == '0);
    assign pushIdx = cntQ[AW-1:0];
    assign popIdx  = AW'(cntQ - 1'b1);

    // Opcode decode: work out the next accumulator, carry and stack count.
    // Failed stack operations leave everything alone except raising the
    // error; a set in the same cycle wins over an error clear.
    always_comb begin
        accD   = accQ;
        carryD = carryQ;
        cntD   = cntQ;
        pushEn = 1'b0;
        errSet = 1'b0;
        case (op_i)
            OP_LOAD: begin
                accD   = dataIn_i;
                carryD = 1'b0;
            end
            OP_ALU: begin
                accD   = aluOut_i;
                carryD = 1'b0;
            end
            OP_CLEAR: begin
                accD   = '0;
                carryD = 1'b0;
            end
            OP_INC: begin
                if (accQ == '1) begin
                    carryD = 1'b1;
                    accD   = (SAT != 0) ? '1 : '0;
                end else begin
                    accD   = accQ + 1'b1;
                    carryD = 1'b0;
                end
            end
            OP_DEC: begin
                if (accQ == '0) begin
                    carryD = 1'b1;
                    accD   = (SAT != 0) ? '0 : '1;
                end else begin
                    accD   = accQ - 1'b1;
                    carryD = 1'b0;
                end
            end
            OP_PUSH: begin
                if (full) begin
                    errSet = 1'b1;
                end else begin
                    pushEn = 1'b1;
                    cntD   = cntQ + 1'b1;
                end
            end
            OP_POP: begin
                if (empty) begin
                    errSet = 1'b1;
                end else begin
                    accD   = stackQ[popIdx];
                    cntD   = cntQ - 1'b1;
                    carryD = 1'b0;
                end
            end
            default: begin
            end
        endcase
        errD = errSet ? 1'b1 : (errClr_i ? 1'b0 : errQ);
    end

    // Architectural state; reset wins over any opcode in the same cycle
    // and drops every saved stack entry by zeroing the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            accQ   <= '0;
            carryQ <= 1'b0;
            errQ   <= 1'b0;
            cntQ   <= '0;
        end else begin
            accQ   <= accD;
            carryQ <= carryD;
            errQ   <= errD;
            cntQ   <= cntD;
        end
    end

    // Stack storage has no reset; only the count decides which entries
    // are valid.
    always_ff @(posedge clk_i) begin
        if (!rst_i && pushEn) begin
            stackQ[pushIdx] <= accQ;
        end
    end

    assign dataOut_o  = accQ;
    assign zero_o     = (accQ == '0);
    assign carry_o    = carryQ;
    assign stkFull_o  = full;
    assign stkEmpty_o = empty;
    assign stkErr_o   = errQ;

endmodule

// File: rtl/acc_bank.sv
// acc_bank: NUM_CH independent accumulator channels, one per core.
// Each channel gets its own 3-bit opcode and WIDTH-bit data slices.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   op           per-channel opcodes, channel i at [3i+2:3i]
//   data_in      per-channel LOAD values
//   alu_out      per-channel ALU results
//   err_clr      per-channel sticky error clear
//   data_out     per-channel accumulator values
//   zero, carry, stk_full, stk_empty, stk_err   per-channel flags
module acc_bank
    import acc_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    parameter int SAT    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OP_W*NUM_CH-1:0]  op,
    input  logic [WIDTH*NUM_CH-1:0] data_in,
    input  logic [WIDTH*NUM_CH-1:0] alu_out,
    input  logic [NUM_CH-1:0]       err_clr,
    output logic [WIDTH*NUM_CH-1:0] data_out,
    output logic [NUM_CH-1:0]       zero,
    output logic [NUM_CH-1:0]       carry,
    output logic [NUM_CH-1:0]       stk_full,
    output logic [NUM_CH-1:0]       stk_empty,
    output logic [NUM_CH-1:0]       stk_err
);

    // One channel instance per core; the bank itself only slices buses.
    for (genvar i = 0; i < NUM_CH; i++) begin : gChannel
        acc_channel #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .SAT   (SAT)
        ) uChannel (
            .clk_i      (clk),
            .rst_i      (rst),
            .op_i       (op[OP_W*i +: OP_W]),
            .dataIn_i   (data_in[WIDTH*i +: WIDTH]),
            .aluOut_i   (alu_out[WIDTH*i +: WIDTH]),
            .errClr_i   (err_clr[i]),
            .dataOut_o  (data_out[WIDTH*i +: WIDTH]),
            .zero_o     (zero[i]),
            .carry_o    (carry[i]),
            .stkFull_o  (stk_full[i]),
            .stkEmpty_o (stk_empty[i]),
            .stkErr_o   (stk_err[i])
        );
    end

endmodule
